// File: rtl/vlg_design.sv
// Paired XOR reference block: raw combinational XOR beside a registered copy.
// A saturating counter reports how often the registered output changed.
module vlg_design #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] z_comb,
    output logic [WIDTH-1:0] z_reg,
    output logic [CNT_W-1:0] toggle_cnt
);

    logic [WIDTH-1:0] z_nxt;
    logic             z_chg;
    logic             cnt_full;

    // Raw XOR: every input edge, including skew glitches, shows up here.
    assign z_comb = a ^ b;

    // Value z_reg will take at the coming edge, and whether it differs.
    always_comb begin
        z_nxt    = a ^ b;
        z_chg    = (z_nxt != z_reg);
        cnt_full = (toggle_cnt == {CNT_W{1'b1}});
    end

    // Glitch-free copy of the XOR, sampled on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_reg <= '0;
        end else begin
            z_reg <= z_nxt;
        end
    end

    // Count edges where z_reg changes; clear wins, and the count sticks at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_cnt <= '0;
        end else if (cnt_clr) begin
            toggle_cnt <= '0;
        end else if (z_chg && !cnt_full) begin
            toggle_cnt <= toggle_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vlg_design.sv
// Bench for vlg_design: one default instance and one WIDTH=4/CNT_W=2 instance,
// directed scenarios followed by random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_vlg_design;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cnt_clr;
    logic       a1, b1;
    logic       zc1, zr1;
    logic [15:0] cnt1;
    logic [3:0] a2, b2;
    logic [3:0] zc2, zr2;
    logic [1:0] cnt2;

    int n_chk = 0;
    int n_fail = 0;

    // behavioural model state
    logic       m1_reg;
    int         m1_cnt;
    logic [3:0] m2_reg;
    int         m2_cnt;
    int         c0;

    always #5 clk = ~clk;

    vlg_design #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cnt_clr(cnt_clr),
        .z_comb(zc1), .z_reg(zr1), .toggle_cnt(cnt1)
    );

    vlg_design #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .cnt_clr(cnt_clr),
        .z_comb(zc2), .z_reg(zr2), .toggle_cnt(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m1_reg = 1'b0;
        m1_cnt = 0;
        m2_reg = 4'h0;
        m2_cnt = 0;
    endtask

    // Spec rules in plain arithmetic: count changes, clamp to 2^CNT_W-1.
    task automatic model_edge();
        logic       n1;
        logic [3:0] n2;
        if (!rst_n) return;
        n1 = a1 ^ b1;
        n2 = a2 ^ b2;
        if (cnt_clr) m1_cnt = 0;
        else if (n1 != m1_reg) m1_cnt = (m1_cnt + 1 > 65535) ? 65535 : m1_cnt + 1;
        if (cnt_clr) m2_cnt = 0;
        else if (n2 != m2_reg) m2_cnt = (m2_cnt + 1 > 3) ? 3 : m2_cnt + 1;
        m1_reg = n1;
        m2_reg = n2;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".zc1"}, 32'(zc1), 32'(a1 ^ b1));
        check({tag, ".zc2"}, 32'(zc2), 32'(a2 ^ b2));
        check({tag, ".zr1"}, 32'(zr1), 32'(m1_reg));
        check({tag, ".zr2"}, 32'(zr2), 32'(m2_reg));
        check({tag, ".cnt1"}, 32'(cnt1), 32'(m1_cnt));
        check({tag, ".cnt2"}, 32'(cnt2), 32'(m2_cnt));
    endtask

    // Advance to next rising edge, update model, check at +1, return at +2.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        cnt_clr = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        a2 = 4'h0; b2 = 4'h0;
        model_reset();

        // reset held for 100 cycles; z_comb must still follow inputs
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                a1 = 1'b1; a2 = 4'h5;
                #1;
                check("rst_zcomb_follow", 32'(zc1), 32'd1);
            end
            if (i == 60) begin
                a1 = 1'b0; a2 = 4'h0;
            end
            tick("reset");
        end
        check("rst_zcomb_zero", 32'(zc1), 32'd0);
        rst_n = 1'b1;

        // simultaneous change
        c0 = cnt1;
        a1 = 1'b1; b1 = 1'b0; #0.5;
        check("sim_zc_1", 32'(zc1), 32'd1);
        tick("sim1");
        check("sim_zr_1", 32'(zr1), 32'd1);
        a1 = 1'b0; b1 = 1'b1; #0.5;
        check("sim_zc_2", 32'(zc1), 32'd1);
        tick("sim2");
        check("sim_zr_2", 32'(zr1), 32'd1);
        a1 = 1'b0; b1 = 1'b0; #0.5;
        check("sim_zc_3", 32'(zc1), 32'd0);
        tick("sim3");
        check("sim_zr_3", 32'(zr1), 32'd0);
        check("sim_cnt_delta", 32'(cnt1) - 32'(c0), 32'd2);

        // skewed change: a at +2, b at +3 (already at +2 here)
        c0 = cnt1;
        a1 = 1'b1; #1; b1 = 1'b0;
        tick("skew1");
        check("skew_zr_1", 32'(zr1), 32'd1);
        a1 = 1'b0; #0.5;
        check("skew_glitch", 32'(zc1), 32'd0);
        #0.5; b1 = 1'b1; #0.5;
        check("skew_zc_after", 32'(zc1), 32'd1);
        tick("skew2");
        check("skew_zr_2", 32'(zr1), 32'd1);
        b1 = 1'b0; #1;
        tick("skew3");
        check("skew_zr_3", 32'(zr1), 32'd0);
        check("skew_cnt_delta", 32'(cnt1) - 32'(c0), 32'd2);

        // saturation on the 2-bit counter
        for (int i = 0; i < 6; i++) begin
            a2[0] = ~a2[0];
            tick("sat");
        end
        check("sat_at_3", 32'(cnt2), 32'd3);
        cnt_clr = 1'b1;
        tick("clr");
        check("clr_zero", 32'(cnt2), 32'd0);
        a2[0] = ~a2[0];
        tick("clr_tog");
        check("clr_with_toggle", 32'(cnt2), 32'd0);
        cnt_clr = 1'b0;

        // mid-operation asynchronous reset
        a1 = 1'b1; b1 = 1'b0;
        tick("pre_rst");
        check("pre_rst_zr", 32'(zr1), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_zr1", 32'(zr1), 32'd0);
        check("async_cnt1", 32'(cnt1), 32'd0);
        check("async_cnt2", 32'(cnt2), 32'd0);
        check("async_zc1", 32'(zc1), 32'd1);
        #2; rst_n = 1'b1;
        tick("post_rst");
        check("reload_zr", 32'(zr1), 32'd1);

        // width case
        a2 = 4'b1010; b2 = 4'b0110; #0.5;
        check("w4_zcomb", 32'(zc2), 32'hC);
        tick("w4");
        check("w4_zreg", 32'(zr2), 32'hC);

        // random traffic, occasional clears and async reset pulses
        for (int i = 0; i < 400; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom);
            a2 = 4'($urandom); b2 = 4'($urandom);
            cnt_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check("rnd_async_zr2", 32'(zr2), 32'd0);
                #1; rst_n = 1'b1;
            end
            tick("rnd");
        end
        cnt_clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
